// File: rtl/apuf_race_ctrl_if.sv
// Host/arbiter-side signal bundle for the APUF race controller.
// Response handshake: a response transfers on a cycle where resp_valid && resp_ready; resp_valid holds until then.
interface apuf_race_ctrl_if #(
    parameter int nCHAL = 64
);
    logic             start;
    logic [nCHAL-1:0] chal_in;
    logic             busy;
    logic [nCHAL-1:0] chal_out;
    logic             launch;
    logic             arb_in;
    logic             resp;
    logic             stable;
    logic [7:0]       ones_cnt;
    logic             resp_valid;
    logic             resp_ready;
    logic [1:0]       state_dbg;

    modport master (
        output start, chal_in, arb_in, resp_ready,
        input  busy, chal_out, launch, resp, stable, ones_cnt, resp_valid, state_dbg
    );

    modport slave (
        input  start, chal_in, arb_in, resp_ready,
        output busy, chal_out, launch, resp, stable, ones_cnt, resp_valid, state_dbg
    );
endinterface

// File: rtl/apuf_race_ctrl.sv
// APUF evaluation controller: drives the challenge, fires NEVAL launch edges into the
// switch chain, majority-votes the synchronized arbiter decisions and returns one response bit.
module apuf_race_ctrl #(
    parameter int nCHAL  = 64,
    parameter int NEVAL  = 15,
    parameter int SETTLE = 16,
    parameter int PRECHG = 8
) (
    input logic             clk,
    input logic             rst,
    apuf_race_ctrl_if.slave bus
);
    localparam int PMAX = (SETTLE > PRECHG) ? SETTLE : PRECHG;
    localparam int CW   = $clog2(PMAX);
    localparam logic [CW-1:0] PRE_LAST = CW'(PRECHG - 1);
    localparam logic [CW-1:0] SET_LAST = CW'(SETTLE - 1);
    localparam logic [7:0]    N_EVAL   = 8'(NEVAL);
    localparam logic [7:0]    N_HALF   = 8'(NEVAL / 2);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRECHG = 2'd1,
        S_FIRE   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    phase_q, phase_d;
    logic [7:0]       eval_q, eval_d;
    logic [7:0]       ones_q, ones_d;
    logic [nCHAL-1:0] chal_q, chal_d;
    logic             busy_q, busy_d;
    logic             launch_q, launch_d;
    logic             resp_q, resp_d;
    logic             stable_q, stable_d;
    logic             valid_q, valid_d;
    logic             arb_meta_q, arb_meta_d;
    logic             arb_s_q, arb_s_d;
    logic [7:0]       eval_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            eval_q     <= '0;
            ones_q     <= '0;
            chal_q     <= '0;
            busy_q     <= 1'b0;
            launch_q   <= 1'b0;
            resp_q     <= 1'b0;
            stable_q   <= 1'b0;
            valid_q    <= 1'b0;
            arb_meta_q <= 1'b0;
            arb_s_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            eval_q     <= eval_d;
            ones_q     <= ones_d;
            chal_q     <= chal_d;
            busy_q     <= busy_d;
            launch_q   <= launch_d;
            resp_q     <= resp_d;
            stable_q   <= stable_d;
            valid_q    <= valid_d;
            arb_meta_q <= arb_meta_d;
            arb_s_q    <= arb_s_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        eval_d     = eval_q;
        ones_d     = ones_q;
        chal_d     = chal_q;
        busy_d     = busy_q;
        resp_d     = resp_q;
        stable_d   = stable_q;
        valid_d    = valid_q;
        arb_meta_d = bus.arb_in;
        arb_s_d    = arb_meta_q;
        eval_nxt   = eval_q + 8'd1;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    chal_d   = bus.chal_in;
                    ones_d   = '0;
                    eval_d   = '0;
                    phase_d  = '0;
                    resp_d   = 1'b0;
                    stable_d = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = S_PRECHG;
                end
            end
            S_PRECHG: begin
                if (phase_q == PRE_LAST) begin
                    phase_d = '0;
                    state_d = S_FIRE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_FIRE: begin
                if (phase_q == SET_LAST) begin
                    // Only the settled decision at the end of the window is counted.
                    phase_d = '0;
                    ones_d  = ones_q + {7'd0, arb_s_q};
                    eval_d  = eval_nxt;
                    if (eval_nxt == N_EVAL) begin
                        resp_d   = (ones_d > N_HALF);
                        stable_d = (ones_d == 8'd0) || (ones_d == N_EVAL);
                        valid_d  = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_PRECHG;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_DONE: begin
                if (valid_q && bus.resp_ready) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered launch follows the next state so it is high exactly while in FIRE.
        launch_d = (state_d == S_FIRE);
    end

    assign bus.busy       = busy_q;
    assign bus.chal_out   = chal_q;
    assign bus.launch     = launch_q;
    assign bus.resp       = resp_q;
    assign bus.stable     = stable_q;
    assign bus.ones_cnt   = ones_q;
    assign bus.resp_valid = valid_q;
    assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_apuf_race_ctrl.sv
// Directed bench for apuf_race_ctrl: default instance (NEVAL=15, SETTLE=16, PRECHG=8)
// plus a minimal instance (NEVAL=1, SETTLE=4, PRECHG=2).
module tb_apuf_race_ctrl;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];
  logic [9:0] got;
  logic [9:0] exp_v;
  int lat;
  int cyc;
  int high_cnt;

  always #5 clk = ~clk;

  apuf_race_ctrl_if #(.nCHAL(64)) bus ();
  apuf_race_ctrl_if #(.nCHAL(64)) bus6 ();

  apuf_race_ctrl #(.nCHAL(64), .NEVAL(15), .SETTLE(16), .PRECHG(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  apuf_race_ctrl #(.nCHAL(64), .NEVAL(1), .SETTLE(4), .PRECHG(2)) dut6 (
    .clk(clk), .rst(rst), .bus(bus6)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_stray(input int c, input logic [63:0] chal, input int s1, input int s2);
    if (c == s1 || c == s2) begin
      bus.start = 1'b1;
      bus.chal_in = ~chal;
    end else begin
      bus.start = 1'b0;
      bus.chal_in = chal;
    end
  endtask

  // Accept a start, walk all 15 evaluations, return the cycle index at which resp_valid is seen.
  task automatic run_eval(input logic [63:0] chal, input logic [14:0] pat,
                          input int s1, input int s2, output int latency);
    int c;
    int bad_launch;
    int bad_chal;
    int early;
    int pulses;
    logic prev;
    bus.chal_in = chal;
    bus.start = 1'b1;
    step();
    c = 1;
    bad_launch = 0;
    bad_chal = 0;
    early = 0;
    pulses = 0;
    prev = 1'b0;
    for (int e = 0; e < 15; e++) begin
      for (int k = 0; k < 8; k++) begin
        drive_stray(c, chal, s1, s2);
        bus.arb_in = k[0] ? pat[e] : ~pat[e];
        if (bus.launch !== 1'b0) bad_launch++;
        if (bus.chal_out !== chal) bad_chal++;
        if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b1) early++;
        prev = bus.launch;
        step();
        c++;
      end
      for (int k = 0; k < 16; k++) begin
        drive_stray(c, chal, s1, s2);
        bus.arb_in = pat[e];
        if (bus.launch !== 1'b1) bad_launch++;
        if (bus.launch === 1'b1 && prev !== 1'b1) pulses++;
        if (bus.chal_out !== chal) bad_chal++;
        if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b1) early++;
        prev = bus.launch;
        step();
        c++;
      end
    end
    bus.start = 1'b0;
    bus.chal_in = chal;
    latency = (bus.resp_valid === 1'b1) ? c : -1;
    check("launch_pattern", 64'(bad_launch), 64'd0);
    check("launch_pulses", 64'(pulses), 64'd15);
    check("chal_out_stable", 64'(bad_chal), 64'd0);
    check("busy_no_early_valid", 64'(early), 64'd0);
    check("launch_low_in_done", 64'(bus.launch), 64'd0);
  endtask

  task automatic handshake(input int hold, input bit start_in_hs, input logic [63:0] chal,
                           output logic [9:0] snap);
    int bad;
    bad = 0;
    snap = {bus.resp, bus.stable, bus.ones_cnt};
    bus.resp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if ({bus.resp, bus.stable, bus.ones_cnt} !== snap || bus.resp_valid !== 1'b1 ||
          bus.busy !== 1'b1 || bus.launch !== 1'b0) bad++;
      step();
    end
    check("done_hold_constant", 64'(bad), 64'd0);
    check("valid_before_hs", 64'(bus.resp_valid), 64'd1);
    bus.resp_ready = 1'b1;
    if (start_in_hs) begin
      bus.start = 1'b1;
      bus.chal_in = ~chal;
    end
    step();
    bus.resp_ready = 1'b0;
    bus.start = 1'b0;
    bus.chal_in = chal;
    check("hs_valid_cleared", 64'({bus.resp_valid, bus.busy}), 64'd0);
    check("hs_state_idle", 64'(bus.state_dbg), 64'd0);
    check("hs_result_kept", 64'({bus.resp, bus.stable, bus.ones_cnt}), 64'(snap));
    step();
    check("post_hs_still_idle", 64'({bus.busy, bus.launch, bus.state_dbg}), 64'd0);
    check("post_hs_chal_kept", bus.chal_out, chal);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.chal_in = '0;
    bus.arb_in = 1'b0;
    bus.resp_ready = 1'b0;
    bus6.start = 1'b0;
    bus6.chal_in = '0;
    bus6.arb_in = 1'b0;
    bus6.resp_ready = 1'b0;
    step();
    step();
    check("rst_outputs", 64'({bus.launch, bus.busy, bus.resp, bus.stable, bus.resp_valid}), 64'd0);
    check("rst_ones_state", 64'({bus.ones_cnt, bus.state_dbg}), 64'd0);
    check("rst_chal_out", bus.chal_out, 64'd0);
    rst = 1'b0;
    step();

    // Reset in the middle of a FIRE window.
    bus.chal_in = 64'h1111_2222_3333_4444;
    bus.arb_in = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 1; i < 20; i++) step();
    check("pre_rst_launch", 64'({bus.launch, bus.busy}), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_outputs", 64'({bus.launch, bus.busy, bus.resp_valid}), 64'd0);
    check("async_rst_counts", 64'({bus.ones_cnt, bus.state_dbg}), 64'd0);
    step();
    rst = 1'b0;
    step();

    // All-ones evaluation with resp_ready held high throughout.
    bus.resp_ready = 1'b1;
    exp_q.push_back(10'h30F);
    run_eval(64'hA5A5_0000_FFFF_1234, 15'h7FFF, -1, -1, lat);
    check("t2_latency", 64'(lat), 64'd361);
    check("t2_chal_out", bus.chal_out, 64'hA5A5_0000_FFFF_1234);
    handshake(0, 1'b0, 64'hA5A5_0000_FFFF_1234, got);
    exp_v = exp_q.pop_front();
    check("t2_result", 64'(got), 64'(exp_v));

    // 7 ones / 8 zeros, response held 50 cycles.
    bus.resp_ready = 1'b0;
    exp_q.push_back(10'h007);
    run_eval(64'h0123_4567_89AB_CDEF, 15'h007F, -1, -1, lat);
    check("t3a_latency", 64'(lat), 64'd361);
    handshake(50, 1'b0, 64'h0123_4567_89AB_CDEF, got);
    exp_v = exp_q.pop_front();
    check("t3a_result", 64'(got), 64'(exp_v));

    // 8 ones / 7 zeros.
    exp_q.push_back(10'h208);
    run_eval(64'hFEDC_BA98_7654_3210, 15'h00FF, -1, -1, lat);
    check("t3b_latency", 64'(lat), 64'd361);
    handshake(2, 1'b0, 64'hFEDC_BA98_7654_3210, got);
    exp_v = exp_q.pop_front();
    check("t3b_result", 64'(got), 64'(exp_v));

    // Stray starts at cycles 5, 200 and in the handshake cycle; pattern 0x1234 has 5 ones.
    exp_q.push_back(10'h005);
    run_eval(64'hDEAD_BEEF_0123_4567, 15'h1234, 5, 200, lat);
    check("t5_latency", 64'(lat), 64'd361);
    handshake(3, 1'b1, 64'hDEAD_BEEF_0123_4567, got);
    exp_v = exp_q.pop_front();
    check("t5_result", 64'(got), 64'(exp_v));

    // Minimal instance: arb_in high through PRECHG and early FIRE, low at the sample.
    bus6.chal_in = 64'h0000_0000_0000_00F0;
    bus6.arb_in = 1'b1;
    bus6.start = 1'b1;
    step();
    bus6.start = 1'b0;
    cyc = 1;
    high_cnt = 0;
    while (cyc < 20 && bus6.resp_valid !== 1'b1) begin
      bus6.arb_in = (cyc <= 2);
      if (bus6.launch === 1'b1) high_cnt++;
      step();
      cyc++;
    end
    check("t6_latency", 64'(cyc), 64'd7);
    check("t6_launch_high", 64'(high_cnt), 64'd4);
    check("t6_result", 64'({bus6.resp, bus6.stable, bus6.ones_cnt}), 64'h100);
    check("t6_chal_out", bus6.chal_out, 64'h0000_0000_0000_00F0);
    bus6.resp_ready = 1'b1;
    step();
    bus6.resp_ready = 1'b0;
    check("t6_hs_idle", 64'({bus6.resp_valid, bus6.busy, bus6.state_dbg}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
